// File: rtl/link_stage_pkg.sv
// Shared stage/role definitions for the Sudoku game-stage controller.
// The VGA, LED, timer and solver blocks import these same codes so that the
// stage value driven by multi_peer_link_stage is decoded consistently.
//   stage_e     : 3-bit stage code carried on the State bus
//   ROLE_*      : meaning of the status (role) bit
package link_stage_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle       = 3'd0,
        StConnecting = 3'd1,
        StLobby      = 3'd2,
        StPlaying    = 3'd3,
        StWin        = 3'd4,
        StLose       = 3'd5
    } stage_e;

    localparam logic ROLE_MASTER = 1'b0;
    localparam logic ROLE_SLAVE  = 1'b1;

endpackage

// File: rtl/link_input_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous inter-board link lines.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (clears every stage)
//   d          : asynchronous input bits
//   q          : bits after STAGES flops
module link_input_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/multi_peer_link_stage.sv
// Game-stage controller and link handshake for NUM_PEERS remote boards.
// Ports:
//   clk, rst_n            : 100 MHz clock, asynchronous active-low reset
//   solo                  : single-board mode, sampled only when leaving IDLE
//   req_connect/start/return : one-cycle click pulses
//   local_finish          : local puzzle solved (level)
//   receive_*             : asynchronous peer lines, one bit per peer
//   send_*                : registered link outputs to the peers
//   game_init             : one-cycle pulse in the first PLAYING cycle
//   status                : role, ROLE_MASTER or ROLE_SLAVE
//   State                 : stage code (stage_e)
//   peers_connected       : synchronised receive_connect
//   link_error            : one-cycle pulse on connect timeout or peer drop
module multi_peer_link_stage
    import link_stage_pkg::*;
#(
    parameter int unsigned NUM_PEERS      = 1,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 solo,
    input  logic                 req_connect,
    input  logic                 req_start,
    input  logic                 req_return,
    input  logic                 local_finish,
    input  logic [NUM_PEERS-1:0] receive_connect,
    input  logic [NUM_PEERS-1:0] receive_start,
    input  logic [NUM_PEERS-1:0] receive_game_finish,
    output logic                 send_connect,
    output logic                 send_start,
    output logic                 send_game_finish,
    output logic                 game_init,
    output logic                 status,
    output logic [STATE_W-1:0]   State,
    output logic [NUM_PEERS-1:0] peers_connected,
    output logic                 link_error
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_PEERS-1:0] rx_connect, rx_start, rx_game_finish;

    link_input_sync #(
        .WIDTH  (3 * NUM_PEERS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({receive_game_finish, receive_start, receive_connect}),
        .q     ({rx_game_finish, rx_start, rx_connect})
    );

    stage_e           stage_q, stage_d;
    logic             status_q, status_d;
    logic             solo_q, solo_d;
    logic             send_connect_q, send_connect_d;
    logic             send_start_q, send_start_d;
    logic             send_finish_q, send_finish_d;
    logic             game_init_q, game_init_d;
    logic             link_error_q, link_error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic all_conn, any_start, any_finish;
    assign all_conn   = &rx_connect;
    assign any_start  = |rx_start;
    assign any_finish = |rx_game_finish;

    always_comb begin
        stage_d        = stage_q;
        status_d       = status_q;
        solo_d         = solo_q;
        send_connect_d = send_connect_q;
        send_start_d   = send_start_q;
        send_finish_d  = send_finish_q;
        link_error_d   = 1'b0;

        unique case (stage_q)
            StIdle: begin
                if (solo && req_start) begin
                    stage_d  = StPlaying;
                    status_d = ROLE_MASTER;
                    solo_d   = 1'b1;
                end else if (!solo && req_connect) begin
                    stage_d        = StConnecting;
                    // A peer already asserting connect means we answered it: slave.
                    status_d       = |rx_connect;
                    solo_d         = 1'b0;
                    send_connect_d = 1'b1;
                end
            end
            StConnecting: begin
                if (req_return) begin
                    stage_d = StIdle;
                end else if (cnt_q == CNT_MAX) begin
                    stage_d      = StIdle;
                    link_error_d = 1'b1;
                end else if (all_conn) begin
                    stage_d = StLobby;
                end
            end
            StLobby: begin
                if (req_return) begin
                    stage_d = StIdle;
                end else if (!all_conn) begin
                    stage_d      = StIdle;
                    link_error_d = 1'b1;
                end else if (status_q == ROLE_MASTER) begin
                    if (req_start) begin
                        stage_d      = StPlaying;
                        send_start_d = 1'b1;
                    end
                end else if (any_start) begin
                    stage_d = StPlaying;
                end
            end
            StPlaying: begin
                if (req_return) begin
                    stage_d = StIdle;
                end else if (!solo_q && !all_conn) begin
                    stage_d      = StIdle;
                    link_error_d = 1'b1;
                end else if (local_finish &&
                             (solo_q || !any_finish || status_q == ROLE_MASTER)) begin
                    // Simultaneous finish: master wins, slave falls through to LOSE.
                    stage_d       = StWin;
                    send_finish_d = !solo_q;
                end else if (!solo_q && any_finish) begin
                    stage_d = StLose;
                end
            end
            StWin, StLose: begin
                if (req_return) begin
                    stage_d = StIdle;
                end
            end
            default: stage_d = StIdle;
        endcase

        if (stage_d == StIdle) begin
            send_connect_d = 1'b0;
            send_start_d   = 1'b0;
            send_finish_d  = 1'b0;
        end

        game_init_d = (stage_d == StPlaying) && (stage_q != StPlaying);

        // Counts only while in CONNECTING, so it is zero on every entry.
        if (stage_q == StConnecting) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q        <= StIdle;
            status_q       <= ROLE_MASTER;
            solo_q         <= 1'b0;
            send_connect_q <= 1'b0;
            send_start_q   <= 1'b0;
            send_finish_q  <= 1'b0;
            game_init_q    <= 1'b0;
            link_error_q   <= 1'b0;
            cnt_q          <= '0;
        end else begin
            stage_q        <= stage_d;
            status_q       <= status_d;
            solo_q         <= solo_d;
            send_connect_q <= send_connect_d;
            send_start_q   <= send_start_d;
            send_finish_q  <= send_finish_d;
            game_init_q    <= game_init_d;
            link_error_q   <= link_error_d;
            cnt_q          <= cnt_d;
        end
    end

    assign State            = stage_q;
    assign status           = status_q;
    assign send_connect     = send_connect_q;
    assign send_start       = send_start_q;
    assign send_game_finish = send_finish_q;
    assign game_init        = game_init_q;
    assign link_error       = link_error_q;
    assign peers_connected  = rx_connect;

endmodule

// File: tb/tb_multi_peer_link_stage.sv
// Bench for multi_peer_link_stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked each cycle against a stage model.
module tb_multi_peer_link_stage;

    localparam int NP = 3;
    localparam int SS = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic solo = 1'b0, req_connect = 1'b0, req_start = 1'b0, req_return = 1'b0;
    logic local_finish = 1'b0;
    logic [NP-1:0] rx_c = '0, rx_s = '0, rx_g = '0;

    logic          send_connect, send_start, send_game_finish, game_init, status, link_error;
    logic [2:0]    state_code;
    logic [NP-1:0] peers_connected;

    multi_peer_link_stage #(
        .NUM_PEERS      (NP),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .solo                (solo),
        .req_connect         (req_connect),
        .req_start           (req_start),
        .req_return          (req_return),
        .local_finish        (local_finish),
        .receive_connect     (rx_c),
        .receive_start       (rx_s),
        .receive_game_finish (rx_g),
        .send_connect        (send_connect),
        .send_start          (send_start),
        .send_game_finish    (send_game_finish),
        .game_init           (game_init),
        .status              (status),
        .State               (state_code),
        .peers_connected     (peers_connected),
        .link_error          (link_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Stages: 0 idle, 1 connecting, 2 lobby, 3 playing, 4 win, 5 lose.
    int m_stage, m_cnt;
    bit m_status, m_solo, m_sc, m_ss, m_sg, m_gi, m_le;
    // Raw peer lines as seen on past clock edges; the design acts on the value
    // that has aged SS edges.
    logic [NP-1:0] qc[$], qs[$], qg[$];

    task automatic model_reset();
        m_stage = 0; m_cnt = 0;
        m_status = 0; m_solo = 0; m_sc = 0; m_ss = 0; m_sg = 0; m_gi = 0; m_le = 0;
        qc.delete(); qs.delete(); qg.delete();
        for (int i = 0; i < SS; i++) begin
            qc.push_back('0); qs.push_back('0); qg.push_back('0);
        end
    endtask

    task automatic model_step();
        logic [NP-1:0] vc, vs, vg;
        bit allc, anyc, anys, anyg, le;
        int nxt;
        vc = qc[SS-1]; vs = qs[SS-1]; vg = qg[SS-1];
        allc = (vc == {NP{1'b1}}); anyc = (vc != 0); anys = (vs != 0); anyg = (vg != 0);
        nxt = m_stage; le = 0;
        case (m_stage)
            0: begin
                if (solo && req_start) begin
                    nxt = 3; m_status = 0; m_solo = 1;
                end else if (!solo && req_connect) begin
                    nxt = 1; m_status = anyc; m_solo = 0; m_sc = 1;
                end
            end
            1: begin
                if (req_return) nxt = 0;
                else if (m_cnt == TO - 1) begin nxt = 0; le = 1; end
                else if (allc) nxt = 2;
            end
            2: begin
                if (req_return) nxt = 0;
                else if (!allc) begin nxt = 0; le = 1; end
                else if (!m_status && req_start) begin nxt = 3; m_ss = 1; end
                else if (m_status && anys) nxt = 3;
            end
            3: begin
                if (req_return) nxt = 0;
                else if (!m_solo && !allc) begin nxt = 0; le = 1; end
                else if (m_solo) begin
                    if (local_finish) nxt = 4;
                end else begin
                    if (local_finish && anyg) nxt = m_status ? 5 : 4;
                    else if (local_finish) nxt = 4;
                    else if (anyg) nxt = 5;
                    if (nxt == 4) m_sg = 1;
                end
            end
            default: begin
                if (req_return) nxt = 0;
            end
        endcase
        m_gi = (nxt == 3) && (m_stage != 3);
        if (m_stage == 1) m_cnt = (m_cnt + 1 > TO - 1) ? TO - 1 : m_cnt + 1;
        else m_cnt = 0;
        if (nxt == 0) begin m_sc = 0; m_ss = 0; m_sg = 0; end
        m_le = le;
        m_stage = nxt;
        qc.push_front(rx_c); void'(qc.pop_back());
        qs.push_front(rx_s); void'(qs.pop_back());
        qg.push_front(rx_g); void'(qg.pop_back());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("State", 32'(state_code), 32'(m_stage));
                check("status", 32'(status), 32'(m_status));
                check("send_connect", 32'(send_connect), 32'(m_sc));
                check("send_start", 32'(send_start), 32'(m_ss));
                check("send_game_finish", 32'(send_game_finish), 32'(m_sg));
                check("game_init", 32'(game_init), 32'(m_gi));
                check("link_error", 32'(link_error), 32'(m_le));
                check("peers_connected", 32'(peers_connected), 32'(qc[SS-1]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_connect();
        req_connect = 1'b1; tick(); req_connect = 1'b0;
    endtask

    task automatic pulse_start();
        req_start = 1'b1; tick(); req_start = 1'b0;
    endtask

    task automatic pulse_return();
        req_return = 1'b1; tick(); req_return = 1'b0;
    endtask

    task automatic go_master_play();
        rx_c = '0; tick(3);
        pulse_connect();
        rx_c = '1; tick(3);
        pulse_start();
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        check("reset_State", 32'(state_code), 0);
        check("reset_send_connect", 32'(send_connect), 0);
        check("reset_game_init", 32'(game_init), 0);

        // Solo game
        solo = 1'b1;
        pulse_start();
        check("solo_State_play", 32'(state_code), 3);
        check("solo_game_init", 32'(game_init), 1);
        solo = 1'b0;
        tick();
        check("solo_game_init_once", 32'(game_init), 0);
        local_finish = 1'b1; tick(); local_finish = 1'b0;
        check("solo_State_win", 32'(state_code), 4);
        check("solo_no_send_gf", 32'(send_game_finish), 0);
        pulse_return();
        check("solo_back_idle", 32'(state_code), 0);

        // Master start, peer finishes first
        pulse_connect();
        check("master_status", 32'(status), 0);
        check("master_State_conn", 32'(state_code), 1);
        check("master_send_connect", 32'(send_connect), 1);
        rx_c = '1;
        tick(2);
        check("master_wait_sync", 32'(state_code), 1);
        tick();
        check("master_State_lobby", 32'(state_code), 2);
        pulse_start();
        check("master_State_play", 32'(state_code), 3);
        check("master_send_start", 32'(send_start), 1);
        check("master_game_init", 32'(game_init), 1);
        rx_g = 3'b010; tick(3);
        check("master_State_lose", 32'(state_code), 5);
        check("master_lose_no_gf", 32'(send_game_finish), 0);
        rx_g = '0;
        pulse_return();
        check("master_idle", 32'(state_code), 0);
        check("master_idle_send_start", 32'(send_start), 0);

        // Slave, then simultaneous finish
        pulse_connect();
        check("slave_status", 32'(status), 1);
        tick();
        check("slave_State_lobby", 32'(state_code), 2);
        pulse_start();
        check("slave_ignores_req_start", 32'(state_code), 2);
        rx_s = 3'b100; tick(2);
        check("slave_start_sync", 32'(state_code), 2);
        tick();
        check("slave_State_play", 32'(state_code), 3);
        rx_g = 3'b001; tick(2);
        local_finish = 1'b1; tick(); local_finish = 1'b0;
        check("slave_tie_lose", 32'(state_code), 5);
        check("slave_tie_no_gf", 32'(send_game_finish), 0);
        rx_g = '0; rx_s = '0;
        pulse_return();
        check("slave_idle", 32'(state_code), 0);

        // Connect timeout with one peer absent
        rx_c = 3'b011; tick(3);
        pulse_connect();
        check("to_State_conn", 32'(state_code), 1);
        tick(15);
        check("to_still_conn", 32'(state_code), 1);
        check("to_no_err_yet", 32'(link_error), 0);
        tick();
        check("to_link_error", 32'(link_error), 1);
        check("to_State_idle", 32'(state_code), 0);
        check("to_send_connect", 32'(send_connect), 0);
        tick();
        check("to_error_pulse", 32'(link_error), 0);

        // Peer drop mid-game
        go_master_play();
        check("drop_setup", 32'(state_code), 3);
        rx_c = 3'b101; tick(2);
        check("drop_sync", 32'(state_code), 3);
        tick();
        check("drop_State", 32'(state_code), 0);
        check("drop_link_error", 32'(link_error), 1);
        check("drop_send_connect", 32'(send_connect), 0);
        check("drop_send_start", 32'(send_start), 0);

        // Asynchronous reset mid-game
        go_master_play();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_State", 32'(state_code), 0);
        check("arst_send_connect", 32'(send_connect), 0);
        check("arst_send_start", 32'(send_start), 0);
        check("arst_peers", 32'(peers_connected), 0);
        check("arst_game_init", 32'(game_init), 0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            solo         = ($urandom_range(0, 3) == 0);
            req_connect  = ($urandom_range(0, 7) == 0);
            req_start    = ($urandom_range(0, 5) == 0);
            req_return   = ($urandom_range(0, 29) == 0);
            local_finish = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 19) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6) rx_c = '1;
                else if (r < 8) rx_c = '0;
                else rx_c = NP'($urandom);
            end
            if ($urandom_range(0, 14) == 0) begin
                rx_s = ($urandom_range(0, 9) < 3) ? NP'($urandom) : '0;
            end
            if ($urandom_range(0, 24) == 0) begin
                rx_g = ($urandom_range(0, 9) < 3) ? NP'($urandom) : '0;
            end
            tick();
        end

        solo = 0; req_connect = 0; req_start = 0; req_return = 0; local_finish = 0;
        tick(2);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
